// File: rtl/dvs_ravens_pkg.sv
// Shared definitions for the DVS-to-RAVENS event path: event and packet
// widths, queue depth, the dispatcher FSM state type and chunk helpers.
package dvs_ravens_pkg;

    localparam int unsigned RAVENS_PKT_BITS   = 8;
    localparam int unsigned EVENT_BITS        = 24;
    localparam int unsigned EVENT_QUEUE_DEPTH = 16;

    // An event must split into a whole number of packet chunks.
    localparam bit EVENT_BITS_ALIGNED = ((EVENT_BITS % RAVENS_PKT_BITS) == 0);

    localparam int unsigned N_CHUNKS       = EVENT_BITS / RAVENS_PKT_BITS;
    localparam int unsigned CHUNK_CNT_BITS = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        SEND    = 2'b10
    } dispatch_state_e;

    // Most significant chunk of an event word; chunks leave MSB-first.
    function automatic logic [RAVENS_PKT_BITS-1:0] top_chunk(
        input logic [EVENT_BITS-1:0] word
    );
        return word[EVENT_BITS-1 -: RAVENS_PKT_BITS];
    endfunction

endpackage

// File: rtl/dvs_event_dispatcher.sv
// Pops DVS events from the FIFO event queue and streams each one toward
// RAVENS as N_CHUNKS packet chunks, MSB-first, with valid/ready handshaking.
module dvs_event_dispatcher
    import dvs_ravens_pkg::*;
#(
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       q_empty,
    input  logic                       q_wr_en,
    input  logic [EVENT_BITS-1:0]      q_event,
    output logic                       q_rd_en,
    output logic [RAVENS_PKT_BITS-1:0] pkt_data,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic                       pkt_last,
    output logic                       busy,
    output logic [CNT_BITS-1:0]        evt_count
);

    if (!EVENT_BITS_ALIGNED) begin : g_align_check
        $error("EVENT_BITS must be a multiple of RAVENS_PKT_BITS");
    end

    localparam logic [CHUNK_CNT_BITS-1:0] CHUNK_LAST = CHUNK_CNT_BITS'(N_CHUNKS - 1);
    localparam logic [CHUNK_CNT_BITS-1:0] CHUNK_ONE  = CHUNK_CNT_BITS'(1'b1);
    localparam logic [CHUNK_CNT_BITS-1:0] CHUNK_ZERO = CHUNK_CNT_BITS'(1'b0);
    localparam logic [CNT_BITS-1:0]       CNT_MAX    = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]       CNT_ONE    = CNT_BITS'(1'b1);

    dispatch_state_e             state_r;
    dispatch_state_e             state_nxt_s;
    logic [EVENT_BITS-1:0]       shift_r;
    logic [CHUNK_CNT_BITS-1:0]   chunk_cnt_r;
    logic [CNT_BITS-1:0]         evt_count_r;
    logic                        rd_en_s;
    logic                        last_s;
    logic                        xfer_s;

    // Decode of the current chunk position and handshake completion.
    always_comb begin
        last_s = 1'b0;
        xfer_s = 1'b0;
        if (state_r == SEND) begin
            last_s = (chunk_cnt_r == CHUNK_LAST);
            xfer_s = pkt_ready;
        end else begin
            last_s = 1'b0;
            xfer_s = 1'b0;
        end
    end

    // Next-state logic and the pop request; a read only starts from IDLE
    // when the queue has data and is not being written this cycle.
    always_comb begin
        state_nxt_s = state_r;
        rd_en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rst && enable && !q_empty && !q_wr_en) begin
                    rd_en_s     = 1'b1;
                    state_nxt_s = CAPTURE;
                end else begin
                    rd_en_s     = 1'b0;
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                state_nxt_s = SEND;
            end
            SEND: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any event in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Event shift register and chunk counter: load in CAPTURE, advance one
    // chunk per accepted transfer in SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r     <= {EVENT_BITS{1'b0}};
            chunk_cnt_r <= CHUNK_ZERO;
        end else begin
            case (state_r)
                CAPTURE: begin
                    shift_r     <= q_event;
                    chunk_cnt_r <= CHUNK_ZERO;
                end
                SEND: begin
                    if (xfer_s) begin
                        shift_r <= shift_r << RAVENS_PKT_BITS;
                        if (last_s) begin
                            chunk_cnt_r <= CHUNK_ZERO;
                        end else begin
                            chunk_cnt_r <= chunk_cnt_r + CHUNK_ONE;
                        end
                    end else begin
                        shift_r     <= shift_r;
                        chunk_cnt_r <= chunk_cnt_r;
                    end
                end
                default: begin
                    shift_r     <= shift_r;
                    chunk_cnt_r <= chunk_cnt_r;
                end
            endcase
        end
    end

    // Dispatched-event counter; sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count_r <= {CNT_BITS{1'b0}};
        end else if (xfer_s && last_s && (evt_count_r != CNT_MAX)) begin
            evt_count_r <= evt_count_r + CNT_ONE;
        end else begin
            evt_count_r <= evt_count_r;
        end
    end

    // Output decode, driven only from the state and datapath registers.
    always_comb begin
        q_rd_en   = rd_en_s;
        pkt_valid = (state_r == SEND);
        pkt_last  = last_s;
        busy      = (state_r != IDLE);
        evt_count = evt_count_r;
        if (state_r == SEND) begin
            pkt_data = top_chunk(shift_r);
        end else begin
            pkt_data = {RAVENS_PKT_BITS{1'b0}};
        end
    end

endmodule

// File: tb/tb_dvs_event_dispatcher.sv
// Self-checking bench for dvs_event_dispatcher: the bench plays the FIFO
// event queue and keeps a chunk-level scoreboard of expected output.
module tb_dvs_event_dispatcher;
    import dvs_ravens_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       enable = 1'b0;
    logic                       q_empty = 1'b1;
    logic                       q_wr_en = 1'b0;
    logic [EVENT_BITS-1:0]      q_event = '0;
    logic                       pkt_ready = 1'b0;
    logic                       q_rd_en, pkt_valid, pkt_last, busy;
    logic [RAVENS_PKT_BITS-1:0] pkt_data;
    logic [15:0]                evt_count;
    logic                       q_rd_en_b, pkt_valid_b, pkt_last_b, busy_b;
    logic [RAVENS_PKT_BITS-1:0] pkt_data_b;
    logic [1:0]                 evt_count_b;

    dvs_event_dispatcher #(.CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .q_empty(q_empty), .q_wr_en(q_wr_en),
        .q_event(q_event), .q_rd_en(q_rd_en), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_last(pkt_last), .busy(busy), .evt_count(evt_count)
    );

    dvs_event_dispatcher #(.CNT_BITS(2)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .q_empty(q_empty), .q_wr_en(q_wr_en),
        .q_event(q_event), .q_rd_en(q_rd_en_b), .pkt_data(pkt_data_b), .pkt_valid(pkt_valid_b),
        .pkt_ready(pkt_ready), .pkt_last(pkt_last_b), .busy(busy_b), .evt_count(evt_count_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [EVENT_BITS-1:0]      fifo[$];
    logic [RAVENS_PKT_BITS-1:0] exp_data[$];
    logic                       exp_last[$];
    int unsigned                done = 0;
    int unsigned                total = 0;

    logic                       s_rd, s_valid, s_last, s_busy;
    logic [RAVENS_PKT_BITS-1:0] s_data;
    logic                       prev_rd = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [RAVENS_PKT_BITS-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic push_event(input logic [EVENT_BITS-1:0] ev);
        fifo.push_back(ev);
        total++;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic cycle();
        logic [EVENT_BITS-1:0] ev;
        logic [RAVENS_PKT_BITS-1:0] ed;
        logic el;
        q_empty = (fifo.size() == 0);
        #1;
        s_rd = q_rd_en; s_valid = pkt_valid; s_data = pkt_data; s_last = pkt_last; s_busy = busy;
        if (s_rd) begin
            chk("rd_guard", 32'({enable, q_wr_en, q_empty}), 32'(3'b100));
            chk("rd_one_cycle", 32'(prev_rd), 32'(1'b0));
        end
        if (prev_stall) begin
            chk("hold_valid", 32'(s_valid), 32'(1'b1));
            chk("hold_data", 32'(s_data), 32'(prev_data));
            chk("hold_last", 32'(s_last), 32'(prev_last));
        end
        if (s_valid) chk("busy_in_send", 32'(s_busy), 32'(1'b1));
        if (s_valid && exp_data.size() == 0) chk("spurious_valid", 32'(s_valid), 32'(1'b0));
        if (s_valid && pkt_ready && exp_data.size() > 0) begin
            ed = exp_data.pop_front();
            el = exp_last.pop_front();
            chk("chunk_data", 32'(s_data), 32'(ed));
            chk("chunk_last", 32'(s_last), 32'(el));
            if (el) done++;
        end
        prev_stall = s_valid && !pkt_ready;
        prev_data  = s_data;
        prev_last  = s_last;
        prev_rd    = s_rd;
        @(posedge clk);
        #1;
        if (s_rd && fifo.size() > 0) begin
            ev = fifo.pop_front();
            q_event = ev;
            for (int k = 0; k < int'(N_CHUNKS); k++) begin
                exp_data.push_back(RAVENS_PKT_BITS'(ev >> (RAVENS_PKT_BITS * (N_CHUNKS - 1 - k))));
                exp_last.push_back(k == int'(N_CHUNKS) - 1);
            end
        end else begin
            q_event = EVENT_BITS'($urandom);
        end
        chk("evt_count", 32'(evt_count), sat(done, 32'hFFFF));
        chk("evt_count_sat", 32'(evt_count_b), sat(done, 3));
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rd", 32'(q_rd_en), 32'(1'b0));
        chk("rst_valid", 32'(pkt_valid), 32'(1'b0));
        chk("rst_last", 32'(pkt_last), 32'(1'b0));
        chk("rst_data", 32'(pkt_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_count", 32'(evt_count), 32'(0));
        exp_data.delete();
        exp_last.delete();
        done = 0; total = fifo.size();
        prev_stall = 1'b0; prev_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        #2;
        enable = 1'b1;
        do_reset();

        // Single event, ready tied high.
        pkt_ready = 1'b1;
        push_event(24'hA5C3F0);
        cycle(); chk("t1_rd", 32'(s_rd), 32'(1'b1));
        cycle(); chk("t1_capture_valid", 32'(s_valid), 32'(1'b0));
                 chk("t1_capture_busy", 32'(s_busy), 32'(1'b1));
        cycle(); chk("t1_c0", 32'(s_data), 32'(8'hA5)); chk("t1_c0_last", 32'(s_last), 32'(1'b0));
        cycle(); chk("t1_c1", 32'(s_data), 32'(8'hC3)); chk("t1_c1_last", 32'(s_last), 32'(1'b0));
        cycle(); chk("t1_c2", 32'(s_data), 32'(8'hF0)); chk("t1_c2_last", 32'(s_last), 32'(1'b1));
        chk("t1_count", 32'(evt_count), 32'(1));
        cycle(); chk("t1_idle_valid", 32'(s_valid), 32'(1'b0)); chk("t1_idle_busy", 32'(s_busy), 32'(1'b0));
        chk("t1_idle_rd", 32'(s_rd), 32'(1'b0));

        // Backpressure on the second chunk.
        push_event(24'hA5C3F0);
        cycle(); cycle(); cycle();
        pkt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_data", 32'(s_data), 32'(8'hC3));
            chk("bp_valid", 32'(s_valid), 32'(1'b1));
        end
        pkt_ready = 1'b1;
        cycle(); chk("bp_release", 32'(s_data), 32'(8'hC3));
        cycle(); chk("bp_final", 32'(s_data), 32'(8'hF0));
        chk("bp_count", 32'(evt_count), 32'(2));

        // Read blocked by queue writes.
        push_event(24'h123456);
        q_wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(); chk("wr_block_rd", 32'(s_rd), 32'(1'b0));
        end
        q_wr_en = 1'b0;
        cycle(); chk("wr_release_rd", 32'(s_rd), 32'(1'b1));
        for (int i = 0; i < 4; i++) cycle();

        // Enable dropped mid-event: event completes, then no new read.
        push_event(24'h0F1E2D);
        push_event(24'h3C4B5A);
        cycle(); chk("en_rd", 32'(s_rd), 32'(1'b1));
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("en_finish_count", 32'(evt_count), 32'(4));
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("en_hold_rd", 32'(s_rd), 32'(1'b0));
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("en_resume_count", 32'(evt_count), 32'(5));

        // Throughput: three events in 15 cycles.
        do_reset();
        push_event(24'h111111); push_event(24'h222222); push_event(24'h333333);
        for (int i = 0; i < 15; i++) cycle();
        chk("tp_last", 32'(s_last), 32'(1'b1));
        chk("tp_done", 32'(exp_data.size()), 32'(0));
        chk("tp_count", 32'(evt_count), 32'(3));

        // Reset during the second chunk.
        push_event(24'hDEADBE);
        cycle(); cycle(); cycle(); cycle();
        chk("rst_mid_chunk", 32'(s_data), 32'(8'hAD));
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("rst_no_valid", 32'(s_valid), 32'(1'b0));
        end
        chk("rst_mid_count", 32'(evt_count), 32'(0));
        enable = 1'b1;

        // Saturation of the narrow counter.
        do_reset();
        for (int i = 0; i < 5; i++) push_event(EVENT_BITS'($urandom));
        for (int i = 0; i < 27; i++) cycle();
        chk("sat_narrow", 32'(evt_count_b), 32'(3));
        chk("sat_wide", 32'(evt_count), 32'(5));

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(3, 0) != 0);
            pkt_ready = ($urandom_range(2, 0) != 0);
            q_wr_en   = ($urandom_range(2, 0) == 0) && (fifo.size() < EVENT_QUEUE_DEPTH);
            cycle();
            if (q_wr_en) push_event(EVENT_BITS'($urandom));
        end
        enable = 1'b1; pkt_ready = 1'b1; q_wr_en = 1'b0;
        n = 0;
        while ((fifo.size() > 0 || exp_data.size() > 0 || busy) && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 32'(1'b1));
        chk("rand_total", 32'(done), 32'(total));
        chk("rand_count", 32'(evt_count), sat(total, 32'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvs_event_dispatcher.md
DVS_EVENT_DISPATCHER -- requirements
Module: dvs_event_dispatcher

Interface
REQ-001 Parameter: CNT_BITS, 16, width of the dispatched-event counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: enable  input  1  permits starting a new queue read; does not abort an event in flight.
REQ-005 Port: q_empty  input  1  empty flag from the FIFO event queue.
REQ-006 Port: q_wr_en  input  1  the queue's write enable, observed so that reads never collide with writes on the shared SRAM address.
REQ-007 Port: q_event  input  EVENT_BITS  queue read data, valid on the cycle after q_rd_en.
REQ-008 Port: q_rd_en  output  1  pop request to the queue.
REQ-009 Port: pkt_data  output  RAVENS_PKT_BITS  current chunk sent toward RAVENS.
REQ-010 Port: pkt_valid  output  1  pkt_data is valid.
REQ-011 Port: pkt_ready  input  1  downstream accepts the chunk this cycle.
REQ-012 Port: pkt_last  output  1  the current chunk is the final chunk of its event.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: evt_count  output  CNT_BITS  number of events fully dispatched; saturates at the maximum value.

Function
REQ-015 The FSM SHALL have three states: IDLE, CAPTURE and SEND.
REQ-016 In IDLE, q_rd_en SHALL be asserted combinationally, for exactly one cycle, when enable=1, q_empty=0 and q_wr_en=0; on that edge the FSM moves to CAPTURE.
REQ-017 q_rd_en SHALL never be asserted while q_wr_en=1, while q_empty=1, or outside IDLE.
REQ-018 CAPTURE SHALL last one cycle: it latches q_event into an EVENT_BITS shift register, clears the chunk counter to 0, and moves to SEND.
REQ-019 The number of chunks per event SHALL be N_CHUNKS = EVENT_BITS/RAVENS_PKT_BITS.
REQ-020 Chunks SHALL be sent MSB-first: chunk k = bits [EVENT_BITS-1-k*RAVENS_PKT_BITS -: RAVENS_PKT_BITS].
REQ-021 In SEND, pkt_valid SHALL be 1 and pkt_data SHALL be taken from the register, not combinationally from q_event.
REQ-022 pkt_last SHALL equal (chunk counter == N_CHUNKS-1) while in SEND, and 0 otherwise.
REQ-023 While pkt_valid=1 and pkt_ready=0, pkt_data, pkt_last and pkt_valid SHALL all hold stable.
REQ-024 A chunk SHALL transfer on a cycle with pkt_valid=1 and pkt_ready=1. On a non-last transfer the counter increments; on the last transfer the FSM returns to IDLE and evt_count increments (saturating).
REQ-025 The minimum throughput SHALL be one event per N_CHUNKS+2 cycles: one read cycle, CAPTURE, then N_CHUNKS SEND cycles.
REQ-026 Deasserting enable mid-event SHALL NOT stop the event; the block finishes it and then stays in IDLE.
REQ-027 Arithmetic widths: the chunk counter is $clog2(N_CHUNKS) bits (at least 1). evt_count does not wrap.

Reset
REQ-028 While rst=1, state=IDLE, q_rd_en=0, pkt_valid=0, pkt_last=0, pkt_data=0, busy=0, evt_count=0, and the shift register and counter are 0.
REQ-029 Reset asserted mid-event SHALL abandon the event immediately, with no further chunks and no count increment. The popped event is lost.

Structure
REQ-030 EVENT_BITS, EVENT_QUEUE_DEPTH, RAVENS_PKT_BITS and the FSM state enum typedef SHALL live in dvs_ravens_pkg, with N_CHUNKS derived there.
REQ-031 The package SHALL guarantee EVENT_BITS % RAVENS_PKT_BITS == 0.
REQ-032 The block is a single flat module, with no sub-modules. Its only connection to the FIFO event queue is the q_* ports.

Verification (EVENT_BITS=24, RAVENS_PKT_BITS=8)
REQ-033 Queue holds event 0xA5C3F0, ready tied to 1. Required response: q_rd_en for 1 cycle, then pkt_data 0xA5, 0xC3, 0xF0 on consecutive cycles, pkt_last only on 0xF0, evt_count=1.
REQ-034 Backpressure: ready low 3 cycles on chunk 2 (0xC3). Required response: 0xC3 and pkt_valid held stable for all 3 cycles, no duplicated or dropped chunk.
REQ-035 q_empty=0 with q_wr_en=1 for 4 cycles. Required response: q_rd_en stays 0 for those 4 cycles and rises on the first cycle q_wr_en=0.
REQ-036 Three queued events with ready=1. Required response: events are emitted in FIFO order, 15 cycles total, evt_count=3.
REQ-037 rst pulsed during chunk 2. Required response: all outputs at reset values within the same cycle, no further pkt_valid until a new read, evt_count=0.
REQ-038 CNT_BITS=2 with 5 events dispatched. Required response: evt_count saturates at 3.
